// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming (7,4) receive path: codeword/data widths,
// the frame receiver state encoding and the bit-counter width.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int CNT_W  = $clog2(CODE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_t;

endpackage

// File: rtl/hamming_rx_shreg.sv
// Indexed shift register for the frame receiver: writes one bit at a given
// index when load is asserted, clears on request, and reports the XOR of its
// contents (forced to 0 when PAR_EN is 0, i.e. no parity bit on the line).
module hamming_rx_shreg #(
    parameter int W      = 7,
    parameter int IW     = 3,
    parameter bit PAR_EN = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [IW-1:0] idx_i,
    input  logic          bit_i,
    output logic [W-1:0]  q_o,
    output logic          par_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next contents: clear wins over an indexed single-bit write.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d[idx_i] = bit_i;
        end
    end

    // Storage register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o   = q_q;
    assign par_o = PAR_EN ? (^q_q) : 1'b0;

endmodule

// File: rtl/hamming_frame_rx.sv
// Serial frame receiver feeding the Hamming (7,4) decoder. Samples rx_bit on
// bit_en strobes, strips start/stop framing and holds each codeword in a
// one-entry valid/ready buffer. frame_err and overrun are one-cycle pulses.
// Optional parity bit after the code bits: define HAMMING_RX_PARITY_EN.
//
// Handshake: code_out/parity_err are meaningful while code_valid=1 and stay
// stable until an edge with code_valid=1 and code_ready=1 transfers the word;
// a frame completing on that same edge replaces it without loss.
module hamming_frame_rx
    import hamming_pkg::*;
#(
    parameter int CODE_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_bit,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_BITS = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(CODE_W - 1);

`ifdef HAMMING_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    rx_state_t           state_q;
    rx_state_t           state_d;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CODE_W-1:0]   sh_q;
    logic                sh_par;
    logic                sh_clr;
    logic                sh_load;
    logic                commit;
    logic                stop_bad;
    logic                perr_d;
    logic [CODE_W-1:0]   code_q;
    logic                valid_q;
    logic                perr_q;
    logic                ferr_q;
    logic                ovr_q;
`ifdef HAMMING_RX_PARITY_EN
    logic                par_cap;
    logic                par_bit_q;
`endif

    hamming_rx_shreg #(
        .W      (CODE_W),
        .IW     (CNT_BITS),
        .PAR_EN (PAR_EN)
    ) u_shreg (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clr_i   (sh_clr),
        .load_i  (sh_load),
        .idx_i   (cnt_q),
        .bit_i   (rx_bit),
        .q_o     (sh_q),
        .par_o   (sh_par)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; only strobed cycles advance the frame.
    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            case (state_q)
                IDLE: if (!rx_bit) state_d = DATA;
                DATA: begin
                    if (cnt_q == LAST_IDX) begin
`ifdef HAMMING_RX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end
                end
                PAR:     state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: datapath strobes decoded from state and the sampled bit.
    always_comb begin
        sh_clr   = 1'b0;
        sh_load  = 1'b0;
        commit   = 1'b0;
        stop_bad = 1'b0;
`ifdef HAMMING_RX_PARITY_EN
        par_cap  = 1'b0;
`endif
        if (bit_en) begin
            case (state_q)
                IDLE: sh_clr = !rx_bit;
                DATA: sh_load = 1'b1;
`ifdef HAMMING_RX_PARITY_EN
                PAR:  par_cap = 1'b1;
`endif
                STOP: begin
                    commit   = rx_bit;
                    stop_bad = !rx_bit;
                end
                default: ;
            endcase
        end
    end

    // Bit counter: cleared on the start bit, advanced per data bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (sh_clr) begin
            cnt_q <= '0;
        end else if (sh_load) begin
            cnt_q <= cnt_q + CNT_BITS'(1);
        end
    end

`ifdef HAMMING_RX_PARITY_EN
    // Parity bit capture, sampled in the PAR slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_bit_q <= 1'b0;
        end else if (par_cap) begin
            par_bit_q <= rx_bit;
        end
    end

    assign perr_d = sh_par ^ par_bit_q;
`else
    assign perr_d = sh_par;
`endif

    // Output buffer: commit/consume/overrun rules plus one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= stop_bad;
            ovr_q  <= 1'b0;
            if (commit) begin
                if (!valid_q || code_ready) begin
                    code_q  <= sh_q;
                    perr_q  <= perr_d;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && code_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_hamming_frame_rx.sv
// Directed bench for hamming_frame_rx: reset, single frame, framing error,
// overrun, back-to-back frames and (with HAMMING_RX_PARITY_EN) parity.
module tb_hamming_frame_rx;

    localparam int W = 7;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         bit_en     = 1'b0;
    logic         rx_bit     = 1'b1;
    logic         code_ready = 1'b0;
    logic [W-1:0] code_out;
    logic         code_valid;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;

    int           n_checks = 0;
    int           n_errors = 0;
    int           gap      = 3;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;

    // Clock.
    always #5 clk = ~clk;

    hamming_frame_rx #(.CODE_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .rx_bit     (rx_bit),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: one strobed cycle, then g idle cycles; returns at a negedge.
    task automatic send_bit(input logic b, input int g);
        bit_en = 1'b1;
        rx_bit = b;
        @(negedge clk);
        bit_en = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    // Full frame; returns at the negedge right after the stop-bit sample.
    task automatic send_frame(input logic [W-1:0] code, input logic stopb,
                              input logic parb, input logic rdy_stop);
        logic saved;
        saved = code_ready;
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) send_bit(code[i], gap);
`ifdef HAMMING_RX_PARITY_EN
        send_bit(parb, gap);
`else
        if (parb) rx_bit = 1'b1;
`endif
        code_ready = rdy_stop;
        send_bit(stopb, 0);
        code_ready = saved;
        rx_bit = 1'b1;
    endtask

    task automatic drain();
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        repeat (2) @(negedge clk);
        check("rst_valid", code_valid, 0);
        check("rst_out", code_out, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_perr", parity_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // A held word, then reset in the middle of a frame.
        send_frame(7'h3C, 1'b1, 1'b0, 1'b0);
        check("pre_valid", code_valid, 1);
        check("pre_out", code_out, 7'h3C);
        repeat (gap) @(negedge clk);
        send_bit(1'b0, gap);
        send_bit(1'b1, gap);
        send_bit(1'b0, gap);
        send_bit(1'b1, gap);
        rst_n  = 1'b0;
        bit_en = 1'b1;
        rx_bit = 1'b0;
        @(negedge clk);
        bit_en = 1'b0;
        rx_bit = 1'b1;
        check("mid_rst_valid", code_valid, 0);
        check("mid_rst_out", code_out, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame 0x55, held until consumed.
        send_frame(7'h55, 1'b1, 1'b0, 1'b0);
        check("s55_valid", code_valid, 1);
        check("s55_out", code_out, 7'h55);
        check("s55_ferr", frame_err, 0);
        repeat (6) @(negedge clk);
        check("s55_hold_valid", code_valid, 1);
        check("s55_hold_out", code_out, 7'h55);
        drain();
        check("s55_drained", code_valid, 0);

        // Framing error: stop bit low.
        send_frame(7'h2A, 1'b0, 1'b1, 1'b0);
        check("ferr_pulse", frame_err, 1);
        check("ferr_valid", code_valid, 0);
        @(negedge clk);
        check("ferr_width", frame_err, 0);
        check("ferr_valid2", code_valid, 0);
        repeat (gap) @(negedge clk);
        send_frame(7'h33, 1'b1, 1'b0, 1'b0);
        check("after_ferr_valid", code_valid, 1);
        check("after_ferr_out", code_out, 7'h33);
        drain();

        // Overrun with the buffer full, then replacement on a consuming edge.
        send_frame(7'h0F, 1'b1, 1'b0, 1'b0);
        check("ov1_valid", code_valid, 1);
        check("ov1_out", code_out, 7'h0F);
        check("ov1_ovr", overrun, 0);
        repeat (gap) @(negedge clk);
        send_frame(7'h70, 1'b1, 1'b1, 1'b0);
        check("ov2_ovr", overrun, 1);
        check("ov2_out", code_out, 7'h0F);
        check("ov2_valid", code_valid, 1);
        @(negedge clk);
        check("ov2_width", overrun, 0);
        check("ov2_out_kept", code_out, 7'h0F);
        repeat (gap) @(negedge clk);
        send_frame(7'h70, 1'b1, 1'b1, 1'b1);
        check("ov3_out", code_out, 7'h70);
        check("ov3_valid", code_valid, 1);
        check("ov3_ovr", overrun, 0);
        drain();
        check("ov3_drained", code_valid, 0);

        // Back-to-back frames with a continuous strobe and ready tied high.
        gap = 0;
        code_ready = 1'b1;
        exp_q.push_back(7'h12);
        exp_q.push_back(7'h6D);
        exp_q.push_back(7'h41);
        for (int k = 0; k < 3; k++) begin
            exp_w = exp_q[k];
            send_frame(exp_w, 1'b1, 1'b0, 1'b1);
            check("b2b_valid", code_valid, 1);
            check("b2b_out", code_out, exp_w);
            check("b2b_ovr", overrun, 0);
        end
        @(negedge clk);
        check("b2b_end_valid", code_valid, 0);
        exp_q.delete();
        code_ready = 1'b0;
        gap = 3;

`ifdef HAMMING_RX_PARITY_EN
        // 0x07 has three ones: parity bit 1 makes the overall parity even.
        send_frame(7'h07, 1'b1, 1'b1, 1'b0);
        check("par_ok_valid", code_valid, 1);
        check("par_ok_perr", parity_err, 0);
        drain();
        send_frame(7'h07, 1'b1, 1'b0, 1'b0);
        check("par_bad_valid", code_valid, 1);
        check("par_bad_out", code_out, 7'h07);
        check("par_bad_perr", parity_err, 1);
        drain();
`else
        send_frame(7'h07, 1'b1, 1'b0, 1'b0);
        check("nopar_valid", code_valid, 1);
        check("nopar_perr", parity_err, 0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
